// File: rtl/slice_loader.sv
// slice_loader: assembles a serial bit stream into N-bit slices and hands
// each slice to a downstream encoder with a valid/ready handshake, SLICES
// slices per frame, then pulses done.
// Optional feature: define SLICE_PARITY_EN to add the slice_par output
// (registered XOR of slice_out, valid with slice_valid).
module slice_loader #(
  parameter int N      = 25,
  parameter int SLICES = 64,
  parameter int IW     = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          din,
  input  logic          din_valid,
  output logic          din_ready,
  output logic [N-1:0]  slice_out,
  output logic [IW-1:0] slice_idx,
  output logic          slice_valid,
  input  logic          slice_ready,
  output logic          busy,
  output logic          done
`ifdef SLICE_PARITY_EN
  ,
  output logic          slice_par
`endif
);

  // state | meaning
  // IDLE  | waiting for start; slice_out/slice_idx hold their last values
  // SHIFT | accepting serial bits into the slice shift register
  // HOLD  | slice complete, slice_valid high until the encoder takes it
  // DONE  | last slice taken; done pulses for this one cycle
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int CW = (N > 2) ? $clog2(N) + 1 : 2;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(SLICES - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  sr_q, sr_d;
  logic [IW-1:0] idx_q, idx_d;

  // Next-state and datapath decode; din_ready is implied by being in SHIFT.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
          idx_d   = '0;
          sr_d    = '0;
        end
      end
      S_SHIFT: begin
        if (din_valid) begin
          sr_d  = {sr_q[N-2:0], din};
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (slice_ready) begin
          if (idx_q == IDX_LAST) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + IW'(1);
            cnt_d   = '0;
            state_d = S_SHIFT;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; synchronous reset wins over every input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      idx_q   <= idx_d;
    end
  end

  assign din_ready   = (state_q == S_SHIFT);
  assign slice_valid = (state_q == S_HOLD);
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign slice_out   = sr_q;
  assign slice_idx   = idx_q;

`ifdef SLICE_PARITY_EN
  logic par_q;

  // Parity tracks the next shift-register value so it lines up with slice_out.
  always_ff @(posedge clk) begin
    if (rst) begin
      par_q <= 1'b0;
    end else begin
      par_q <= ^sr_d;
    end
  end

  assign slice_par = par_q;
`endif

endmodule

// File: tb/tb_slice_loader.sv
// Directed self-checking bench for slice_loader (SLICES=2, N=25).
module tb_slice_loader;

  localparam int N      = 25;
  localparam int SLICES = 2;
  localparam int IW     = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          din;
  logic          din_valid;
  logic          din_ready;
  logic [N-1:0]  slice_out;
  logic [IW-1:0] slice_idx;
  logic          slice_valid;
  logic          slice_ready;
  logic          busy;
  logic          done;
`ifdef SLICE_PARITY_EN
  logic          slice_par;
`endif

  int n_cmp = 0;
  int n_err = 0;

  slice_loader #(.N(N), .SLICES(SLICES), .IW(IW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .din         (din),
    .din_valid   (din_valid),
    .din_ready   (din_ready),
    .slice_out   (slice_out),
    .slice_idx   (slice_idx),
    .slice_valid (slice_valid),
    .slice_ready (slice_ready),
    .busy        (busy),
    .done        (done)
`ifdef SLICE_PARITY_EN
    ,
    .slice_par   (slice_par)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    din       = b;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; din = 1'b0; din_valid = 1'b0; slice_ready = 1'b0;
    tick(); tick();
    n_cmp++;
    if ({slice_valid, din_ready, busy, done} !== 4'b0000) begin
      n_err++; $display("FAIL reset_flags: got %b expected 0000", {slice_valid, din_ready, busy, done});
    end
    n_cmp++;
    if (slice_out !== 25'h0 || slice_idx !== 8'd0) begin
      n_err++; $display("FAIL reset_data: got out=%h idx=%0d expected 0/0", slice_out, slice_idx);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    slice_ready = 1'b1;
    do_start();
    n_cmp++;
    if (din_ready !== 1'b1 || busy !== 1'b1 || slice_out !== 25'h0) begin
      n_err++; $display("FAIL basic_start: got rdy=%b busy=%b out=%h expected 1 1 0", din_ready, busy, slice_out);
    end
    for (int i = 0; i < 24; i++) send_bit((i % 2) == 0);
    n_cmp++;
    if (slice_valid !== 1'b0) begin
      n_err++; $display("FAIL basic_early_valid: got %b expected 0", slice_valid);
    end
    send_bit(1'b1);
    n_cmp++;
    if (slice_valid !== 1'b1 || slice_out !== 25'h1555555 || slice_idx !== 8'd0) begin
      n_err++; $display("FAIL basic_slice0: got v=%b out=%h idx=%0d expected 1 1555555 0", slice_valid, slice_out, slice_idx);
    end
    tick();
    n_cmp++;
    if (slice_valid !== 1'b0 || din_ready !== 1'b1 || slice_idx !== 8'd1) begin
      n_err++; $display("FAIL basic_take0: got v=%b rdy=%b idx=%0d expected 0 1 1", slice_valid, din_ready, slice_idx);
    end
    for (int i = 25; i < 50; i++) send_bit((i % 2) == 0);
    n_cmp++;
    if (slice_valid !== 1'b1 || slice_out !== 25'h0AAAAAA || slice_idx !== 8'd1) begin
      n_err++; $display("FAIL basic_slice1: got v=%b out=%h idx=%0d expected 1 0aaaaaa 1", slice_valid, slice_out, slice_idx);
    end
    tick();
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b1 || slice_valid !== 1'b0) begin
      n_err++; $display("FAIL basic_done: got done=%b busy=%b v=%b expected 1 1 0", done, busy, slice_valid);
    end
    tick();
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || slice_out !== 25'h0AAAAAA || slice_idx !== 8'd1) begin
      n_err++; $display("FAIL basic_idle_hold: got done=%b busy=%b out=%h idx=%0d expected 0 0 0aaaaaa 1", done, busy, slice_out, slice_idx);
    end
    slice_ready = 1'b0;
  endtask

  task automatic test_stall();
    logic [N-1:0] snap;
    do_start();
    for (int i = 0; i < 10; i++) send_bit(1'b1);
    snap = slice_out;
    din = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    n_cmp++;
    if (snap !== 25'h00003FF || slice_out !== 25'h00003FF || din_ready !== 1'b1) begin
      n_err++; $display("FAIL stall_hold: got before=%h after=%h rdy=%b expected 00003ff 00003ff 1", snap, slice_out, din_ready);
    end
    for (int i = 0; i < 14; i++) send_bit(1'b0);
    n_cmp++;
    if (slice_valid !== 1'b0) begin
      n_err++; $display("FAIL stall_early_valid: got %b expected 0 at cycle 27", slice_valid);
    end
    send_bit(1'b0);
    n_cmp++;
    if (slice_valid !== 1'b1 || slice_out !== 25'h1FF8000) begin
      n_err++; $display("FAIL stall_slice: got v=%b out=%h expected 1 1ff8000 at cycle 28", slice_valid, slice_out);
    end
    do_reset();
  endtask

  task automatic test_backpressure();
    do_start();
    for (int i = 0; i < 25; i++) send_bit((i % 3) == 0);
    slice_ready = 1'b0; din = 1'b1; din_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_cmp++;
      if (slice_valid !== 1'b1 || slice_out !== 25'h1249249 || slice_idx !== 8'd0 || din_ready !== 1'b0) begin
        n_err++; $display("FAIL bp_hold[%0d]: got v=%b out=%h idx=%0d rdy=%b expected 1 1249249 0 0", c, slice_valid, slice_out, slice_idx, din_ready);
      end
    end
    slice_ready = 1'b1;
    tick();
    n_cmp++;
    if (slice_valid !== 1'b0 || slice_idx !== 8'd1 || slice_out !== 25'h1249249) begin
      n_err++; $display("FAIL bp_take: got v=%b idx=%0d out=%h expected 0 1 1249249", slice_valid, slice_idx, slice_out);
    end
    slice_ready = 1'b0; din_valid = 1'b0;
    do_reset();
  endtask

  task automatic test_reset_mid();
    do_start();
    for (int i = 0; i < 12; i++) send_bit(1'b1);
    rst = 1'b1; start = 1'b1; din_valid = 1'b1; slice_ready = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0; din_valid = 1'b0; slice_ready = 1'b0;
    n_cmp++;
    if ({slice_valid, din_ready, busy, done} !== 4'b0000 || slice_out !== 25'h0 || slice_idx !== 8'd0) begin
      n_err++; $display("FAIL rstmid_outputs: got flags=%b out=%h idx=%0d expected 0000 0 0", {slice_valid, din_ready, busy, done}, slice_out, slice_idx);
    end
    tick(); tick();
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL rstmid_no_done: got done=%b busy=%b expected 0 0", done, busy);
    end
    do_start();
    send_bit(1'b1);
    for (int i = 1; i < 25; i++) send_bit(1'b0);
    n_cmp++;
    if (slice_valid !== 1'b1 || slice_out !== 25'h1000000 || slice_idx !== 8'd0) begin
      n_err++; $display("FAIL rstmid_fresh: got v=%b out=%h idx=%0d expected 1 1000000 0", slice_valid, slice_out, slice_idx);
    end
    do_reset();
  endtask

  task automatic test_start_busy();
    do_start();
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++;
    if (slice_out !== 25'h000001F || busy !== 1'b1 || din_ready !== 1'b1) begin
      n_err++; $display("FAIL busy_start_shift: got out=%h busy=%b rdy=%b expected 000001f 1 1", slice_out, busy, din_ready);
    end
    for (int i = 0; i < 20; i++) send_bit(1'b0);
    n_cmp++;
    if (slice_valid !== 1'b1 || slice_out !== 25'h1F00000 || slice_idx !== 8'd0) begin
      n_err++; $display("FAIL busy_slice0: got v=%b out=%h idx=%0d expected 1 1f00000 0", slice_valid, slice_out, slice_idx);
    end
    slice_ready = 1'b1;
    tick();
    slice_ready = 1'b0;
    for (int i = 0; i < 25; i++) send_bit(1'b1);
    n_cmp++;
    if (slice_valid !== 1'b1 || slice_out !== 25'h1FFFFFF || slice_idx !== 8'd1) begin
      n_err++; $display("FAIL busy_slice1: got v=%b out=%h idx=%0d expected 1 1ffffff 1", slice_valid, slice_out, slice_idx);
    end
    slice_ready = 1'b1;
    tick();
    slice_ready = 1'b0;
    n_cmp++;
    if (done !== 1'b1) begin
      n_err++; $display("FAIL busy_done: got %b expected 1", done);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || din_ready !== 1'b0 || done !== 1'b0 || slice_idx !== 8'd1) begin
      n_err++; $display("FAIL busy_start_done: got busy=%b rdy=%b done=%b idx=%0d expected 0 0 0 1", busy, din_ready, done, slice_idx);
    end
    tick();
  endtask

`ifdef SLICE_PARITY_EN
  task automatic test_parity();
    do_start();
    for (int i = 0; i < 25; i++) send_bit(i >= 22);
    n_cmp++;
    if (slice_valid !== 1'b1 || slice_out !== 25'h0000007 || slice_par !== 1'b1) begin
      n_err++; $display("FAIL parity_odd: got v=%b out=%h par=%b expected 1 0000007 1", slice_valid, slice_out, slice_par);
    end
    slice_ready = 1'b1;
    tick();
    slice_ready = 1'b0;
    for (int i = 0; i < 25; i++) send_bit(i >= 23);
    n_cmp++;
    if (slice_valid !== 1'b1 || slice_out !== 25'h0000003 || slice_par !== 1'b0) begin
      n_err++; $display("FAIL parity_even: got v=%b out=%h par=%b expected 1 0000003 0", slice_valid, slice_out, slice_par);
    end
    do_reset();
    n_cmp++;
    if (slice_par !== 1'b0) begin
      n_err++; $display("FAIL parity_reset: got %b expected 0", slice_par);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_backpressure();
    test_reset_mid();
    test_start_busy();
`ifdef SLICE_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
